// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU load/store at a time, checks alignment and
// data-segment bounds, performs sub-word stores as read-modify-write, and
// returns a single-cycle response with sign/zero-extended load data.
module load_store_unit #(
   parameter logic [31:0] DATA_START = 32'h10000000,
   parameter int unsigned DATA_WORDS = 'h40000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [7:0]  err_count,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   // One past the last byte of the data segment, kept 33 bits wide so a
   // segment ending at the top of the address space does not wrap.
   localparam logic [32:0] DATA_END = {1'b0, DATA_START} + {DATA_WORDS[30:0], 2'b00};

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state;
   state_t      state_next;
   logic        accept;
   logic        req_bad;
   logic [7:0]  err_cnt;

   // Request fields captured at accept, and the memory word captured in RD.
   logic        write_p0;
   logic [1:0]  size_p0;
   logic        signed_p0;
   logic [31:0] addr_p0;
   logic [31:0] wdata_p0;
   logic        error_p0;
   logic [31:0] old_word_p1;

   // Misaligned, reserved-size, or outside the data segment.
   function automatic logic is_bad(input logic [1:0] size, input logic [31:0] addr);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr[0];
         SZ_WORD: bad = (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      if (addr < DATA_START || {1'b0, addr} >= DATA_END)
         bad = 1'b1;
      return bad;
   endfunction

   // Pick the addressed lane(s) of a little-endian word and extend to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] offs,
                                                input logic [1:0] size, input logic sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      case (offs)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = offs[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = sgn ? 32'(b) : {24'd0, b};
         SZ_HALF: r = sgn ? 32'(h) : {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed lane(s) of the old word with the store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] offs, input logic [1:0] size);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: begin
            case (offs)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (offs[1]) r[31:16] = wdata[15:0];
            else         r[15:0]  = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

   assign req_ready = (state == IDLE) && reset;
   assign accept    = req_valid && req_ready;
   assign req_bad   = is_bad(req_size, req_addr);

   // Next-state selection for the request sequencer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_bad)
                  state_next = RESP;
               else if (req_write && req_size == SZ_WORD)
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD:      state_next = write_p0 ? WR : RESP;
         WR:      state_next = RESP;
         default: state_next = IDLE;
      endcase
   end

   // State register and saturating rejected-request counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         err_cnt <= 8'd0;
      end else begin
         state <= state_next;
         if (accept && req_bad && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

   // Stage p0: capture the request fields at accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         write_p0  <= req_write;
         size_p0   <= req_size;
         signed_p0 <= req_signed;
         addr_p0   <= req_addr;
         wdata_p0  <= req_wdata;
         error_p0  <= req_bad;
      end
   end

   // Stage p1: capture the memory word read during RD.
   always_ff @(posedge clk) begin
      if (state == RD)
         old_word_p1 <= mem_data_out;
   end

   assign err_count   = err_cnt;
   assign mem_read    = (state == RD);
   assign mem_write   = (state == WR);
   assign mem_addr    = (state == RD || state == WR) ? {addr_p0[31:2], 2'b00} : 32'd0;
   assign mem_data_in = (state == WR) ? store_merge(old_word_p1, wdata_p0, addr_p0[1:0], size_p0)
                                      : 32'd0;
   assign resp_valid  = (state == RESP);
   assign resp_error  = (state == RESP) && error_p0;
   assign resp_rdata  = (state == RESP && !error_p0 && !write_p0)
                        ? load_extract(old_word_p1, addr_p0[1:0], size_p0, signed_p0) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of loads, stores and
// rejected requests against a small memory model, plus hand-written sequences
// for reset behaviour and error-counter saturation.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [7:0]  err_count;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   int checks = 0;
   int passed = 0;
   int exp_errs = 0;

   // 16-word memory window; word index taken from address bits [5:2].
   logic [31:0] mem [16] = '{32'hCAFEF00D, 32'h8899AABB, 32'h11223344, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0BADC0DE};

   load_store_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .err_count(err_count), .mem_addr(mem_addr),
      .mem_read(mem_read), .mem_write(mem_write), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   assign mem_data_out = mem[mem_addr[5:2]];

   // Memory model: synchronous write.
   always @(posedge clk) begin
      if (mem_write)
         mem[mem_addr[5:2]] <= mem_data_in;
   end

   typedef struct {
      string       name;
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_reads;
      int          exp_writes;
      logic [31:0] exp_word;   // stores: word written and memory content afterwards
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      int reads;
      int writes;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = v.write;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      check({v.name, " ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; reads = 0; writes = 0;
      while (!resp_valid && lat < 10) begin
         if (mem_read && mem_write) check({v.name, " rd_wr_overlap"}, 32'd1, 32'd0);
         if (req_ready) check({v.name, " busy_ready"}, 32'(req_ready), 32'd0);
         if (mem_read || mem_write)
            check({v.name, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
         if (mem_read) reads++;
         if (mem_write) begin
            writes++;
            check({v.name, " mem_data_in"}, mem_data_in, v.exp_word);
         end
         @(negedge clk);
         lat++;
      end
      check({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
      check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
      check({v.name, " resp_error"}, 32'(resp_error), 32'(v.exp_err));
      check({v.name, " resp_rdata"}, resp_rdata, v.exp_rdata);
      check({v.name, " reads"}, 32'(reads), 32'(v.exp_reads));
      check({v.name, " writes"}, 32'(writes), 32'(v.exp_writes));
      if (v.exp_err) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
      check({v.name, " err_count"}, 32'(err_count), 32'(exp_errs));
      if (v.write && !v.exp_err)
         check({v.name, " mem_word"}, mem[v.addr[5:2]], v.exp_word);
      @(negedge clk);
      check({v.name, " resp_pulse"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      //            name        wr  size   sg  addr          wdata         err  rdata         lat rd wr word
      vecs[0]  = '{"lb_s",      0, 2'b00, 1, 32'h10000005, 32'h0,        0, 32'hFFFFFFAA, 2, 1, 0, 32'h0};
      vecs[1]  = '{"lbu",       0, 2'b00, 0, 32'h10000005, 32'h0,        0, 32'h000000AA, 2, 1, 0, 32'h0};
      vecs[2]  = '{"lh_s_hi",   0, 2'b01, 1, 32'h10000006, 32'h0,        0, 32'hFFFF8899, 2, 1, 0, 32'h0};
      vecs[3]  = '{"lhu_lo",    0, 2'b01, 0, 32'h10000004, 32'h0,        0, 32'h0000AABB, 2, 1, 0, 32'h0};
      vecs[4]  = '{"lw",        0, 2'b10, 0, 32'h10000004, 32'h0,        0, 32'h8899AABB, 2, 1, 0, 32'h0};
      vecs[5]  = '{"lb_s_b3",   0, 2'b00, 1, 32'h10000007, 32'h0,        0, 32'hFFFFFF88, 2, 1, 0, 32'h0};
      vecs[6]  = '{"sh_hi",     1, 2'b01, 0, 32'h10000006, 32'h00001234, 0, 32'h0,        3, 1, 1, 32'h1234AABB};
      vecs[7]  = '{"sb_b0",     1, 2'b00, 0, 32'h10000008, 32'hFFFFFF55, 0, 32'h0,        3, 1, 1, 32'h11223355};
      vecs[8]  = '{"sw",        1, 2'b10, 0, 32'h10000000, 32'hDEADBEEF, 0, 32'h0,        2, 0, 1, 32'hDEADBEEF};
      vecs[9]  = '{"sw_misal",  1, 2'b10, 0, 32'h10000002, 32'h12345678, 1, 32'h0,        1, 0, 0, 32'h0};
      vecs[10] = '{"lw_below",  0, 2'b10, 0, 32'h0FFFFFFC, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0};
      vecs[11] = '{"lw_above",  0, 2'b10, 0, 32'h10100000, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0};
      vecs[12] = '{"size11",    0, 2'b11, 0, 32'h10000004, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0};
      vecs[13] = '{"lh_misal",  0, 2'b01, 1, 32'h10000005, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0};
      vecs[14] = '{"lw_last",   0, 2'b10, 0, 32'h100FFFFC, 32'h0,        0, 32'h0BADC0DE, 2, 1, 0, 32'h0};

      // Asynchronous reset: outputs clear without a clock edge.
      #3 reset = 1'b0;
      #1;
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst resp", {29'd0, resp_valid, resp_error, mem_read}, 32'd0);
      check("rst mem_write", 32'(mem_write), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst mem_data_in", mem_data_in, 32'd0);
      check("rst rdata", resp_rdata, 32'd0);
      check("rst err_count", 32'(err_count), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 15; i++)
         run_vec(vecs[i]);

      // Continuous rejected requests: counter must saturate at 255.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0FFFFFFC;
      repeat (700) @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("err_sat", 32'(err_count), 32'd255);

      // Reset during the WR cycle of a byte store: write suppressed.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h10000008; req_wdata = 32'h00000077;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("sb_rst rd", 32'(mem_read), 32'd1);
      @(negedge clk);
      check("sb_rst wr", 32'(mem_write), 32'd1);
      reset = 1'b0;
      #1;
      check("sb_rst wr_drop", 32'(mem_write), 32'd0);
      check("sb_rst mem_addr", mem_addr, 32'd0);
      check("sb_rst mem_data_in", mem_data_in, 32'd0);
      check("sb_rst resp", {30'd0, resp_valid, resp_error}, 32'd0);
      check("sb_rst err_count", 32'(err_count), 32'd0);
      check("sb_rst ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("sb_rst mem_word", mem[2], 32'h11223355);
      check("sb_rst no_resp", 32'(resp_valid), 32'd0);
      exp_errs = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      // First edge after reset release accepts a request.
      run_vec('{"lw_post_rst", 0, 2'b10, 0, 32'h10000008, 32'h0, 0, 32'h11223355, 2, 1, 0, 32'h0});
      run_vec('{"sw_err_first", 1, 2'b10, 0, 32'h10000002, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_START, default 32'h10000000, first byte address of the data segment.
REQ-002 Parameter DATA_WORDS, default 'h40000, size of the data segment in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 req_valid  input  1  CPU presents a load/store request.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  one-cycle pulse: request complete.
REQ-013 resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-014 resp_error  output  1  valid with resp_valid; request rejected.
REQ-015 err_count  output  8  saturating count of rejected requests.
REQ-016 mem_addr  output  32  word address to data memory, bits [1:0] always 00.
REQ-017 mem_read  output  1  data-memory read enable; read data is combinational.
REQ-018 mem_write  output  1  data-memory write enable; memory writes on posedge clk.
REQ-019 mem_data_in  output  32  full word to write.
REQ-020 mem_data_out  input  32  word read from memory, valid in the same cycle as mem_read.

Function
REQ-021 FSM states SHALL be IDLE, RD, WR, RESP; req_ready = 1 only in IDLE with reset high.
REQ-022 Accept on req_valid & req_ready; latch write, size, signed, addr and wdata at that edge.
REQ-023 Error conditions: size 11; halfword with addr[0]=1; word with addr[1:0]!=0; addr < DATA_START or addr >= DATA_START + 4*DATA_WORDS.
REQ-024 Error path: IDLE->RESP; resp_error=1; no mem_read or mem_write at any point; err_count increments and saturates at 255.
REQ-025 Load path: IDLE->RD->RESP; RD drives mem_read=1 and captures mem_data_out at the end of the cycle; resp_valid 2 cycles after accept.
REQ-026 Word store path: IDLE->WR->RESP; WR drives mem_write=1 with mem_data_in=wdata for exactly one cycle; latency 2.
REQ-027 Sub-word store path: IDLE->RD->WR->RESP.
  - RD captures the old word.
  - WR writes the old word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Latency 3.
REQ-028 Byte lanes are little-endian: byte k occupies bits [8k+7:8k]; a halfword at offset 2 occupies [31:16].
REQ-029 Load extraction: select the lane(s) by addr[1:0], then sign- or zero-extend per req_signed; words pass through unchanged.
REQ-030 RESP lasts exactly one cycle, then returns to IDLE; responses are not back-pressured.
REQ-031 mem_addr = {addr[31:2],2'b00} while in RD or WR, otherwise 0.
REQ-032 mem_data_in = 0 outside WR.
REQ-033 mem_read and mem_write are never both 1 in the same cycle.
REQ-034 req_valid is ignored outside IDLE; requests are never queued.

Reset
REQ-035 reset=0 SHALL immediately force the following, independent of clk:
  - state IDLE;
  - req_ready, resp_valid, resp_error, mem_read, mem_write = 0;
  - resp_rdata, mem_addr, mem_data_in = 0;
  - err_count = 0.
REQ-036 Reset asserted mid-operation aborts the request with no response; reset asserted during WR drops mem_write before the next edge, so no write occurs.
REQ-037 After reset deasserts, the first posedge may accept a request.

Verification
REQ-038 Memory word 0x10000004 = 32'h8899AABB; lb at 0x10000005, signed -> resp_rdata 32'hFFFFFFAA two cycles after accept; lbu at the same address -> 32'h000000AA.
REQ-039 Same word; sh wdata 32'h00001234 at 0x10000006 -> one mem_read cycle, then one mem_write cycle with mem_data_in 32'h1234AABB; resp_valid 3 cycles after accept.
REQ-040 sw at 0x10000002 -> resp_valid with resp_error=1 one cycle after accept; mem_read and mem_write stay 0; err_count 0 -> 1.
REQ-041 lw at 0x0FFFFFFC and lw at 0x10100000 -> both rejected; 300 consecutive errors -> err_count holds at 255.
REQ-042 sb accepted, reset pulled low during the WR cycle -> mem_write falls immediately and the memory word is unchanged; all outputs 0 until reset rises.
